// File: rtl/truth_table_sweeper.sv
// Steps every input vector of an N-input combinational block, holds each for
// HOLD_CYCLES cycles, and checks the sampled output against an expected truth table.
module truth_table_sweeper #(
   parameter int unsigned N           = 4,
   parameter int unsigned HOLD_CYCLES = 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [(1 << N)-1:0]    expected,
   input  logic                   f,
   output logic [N-1:0]           vec,
   output logic                   busy,
   output logic                   done,
   output logic                   pass,
   output logic [N:0]             err_count,
   output logic [N-1:0]           first_fail,
   output logic                   fail_valid
);

   localparam int unsigned NUM_VEC = 32'(1) << N;
   localparam int unsigned HW      = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
   localparam logic [N-1:0]  VEC_LAST  = N'(NUM_VEC - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRIVE = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t               state;
   logic [HW-1:0]        hold_cnt;
   logic [NUM_VEC-1:0]   expected_q;

   logic                 sample_c;
   logic                 mismatch_c;
   logic [N:0]           err_next_c;

   // Sample strobe and the error count including the current sample, so the
   // last vector's result reaches pass in the same edge that enters DONE.
   always_comb begin
      sample_c   = (state == DRIVE) && (hold_cnt == HOLD_LAST);
      mismatch_c = sample_c && (f != expected_q[vec]);
      err_next_c = err_count + (N+1)'(mismatch_c);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         vec        <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         pass       <= 1'b0;
         err_count  <= '0;
         first_fail <= '0;
         fail_valid <= 1'b0;
         hold_cnt   <= '0;
         expected_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               vec  <= '0;
               busy <= 1'b0;
               done <= 1'b0;
               if (start) begin
                  expected_q <= expected;
                  err_count  <= '0;
                  first_fail <= '0;
                  fail_valid <= 1'b0;
                  pass       <= 1'b0;
                  hold_cnt   <= '0;
                  busy       <= 1'b1;
                  state      <= DRIVE;
               end
            end

            DRIVE: begin
               if (sample_c) begin
                  err_count <= err_next_c;
                  if (mismatch_c && !fail_valid) begin
                     first_fail <= vec;
                     fail_valid <= 1'b1;
                  end
                  if (vec == VEC_LAST) begin
                     done  <= 1'b1;
                     pass  <= (err_next_c == '0);
                     state <= DONE;
                  end else begin
                     vec      <= vec + N'(1);
                     hold_cnt <= '0;
                  end
               end else begin
                  hold_cnt <= hold_cnt + HW'(1);
               end
            end

            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               vec   <= '0;
               state <= IDLE;
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: two instances (H=1, H=3) driven by a table-based DUT
// model; expectations come from comparing the DUT table with the mask directly.
module tb_truth_table_sweeper;

   logic        clk = 1'b0;
   logic        rst;
   logic        start_a, start_b;
   logic [15:0] expected;
   logic [15:0] tt;
   logic        sel;

   logic [3:0]  vec_a, vec_b, first_fail_a, first_fail_b;
   logic [4:0]  err_a, err_b;
   logic        busy_a, busy_b, done_a, done_b, pass_a, pass_b, fv_a, fv_b;
   logic        f_a, f_b;

   logic [3:0]  o_vec, o_ff;
   logic [4:0]  o_err;
   logic        o_busy, o_done, o_pass, o_fv;

   int n_checks = 0;
   int n_errors = 0;
   logic [15:0] good_tt;

   always #5 clk = ~clk;

   // Combinational device under sweep: output is a lookup in tt
   assign f_a = tt[vec_a];
   assign f_b = tt[vec_b];

   assign o_vec  = sel ? vec_b        : vec_a;
   assign o_busy = sel ? busy_b       : busy_a;
   assign o_done = sel ? done_b       : done_a;
   assign o_pass = sel ? pass_b       : pass_a;
   assign o_err  = sel ? err_b        : err_a;
   assign o_ff   = sel ? first_fail_b : first_fail_a;
   assign o_fv   = sel ? fv_b         : fv_a;

   truth_table_sweeper #(.N(4), .HOLD_CYCLES(1)) u_h1 (
      .clk(clk), .rst(rst), .start(start_a), .expected(expected), .f(f_a),
      .vec(vec_a), .busy(busy_a), .done(done_a), .pass(pass_a),
      .err_count(err_a), .first_fail(first_fail_a), .fail_valid(fv_a)
   );

   truth_table_sweeper #(.N(4), .HOLD_CYCLES(3)) u_h3 (
      .clk(clk), .rst(rst), .start(start_b), .expected(expected), .f(f_b),
      .vec(vec_b), .busy(busy_b), .done(done_b), .pass(pass_b),
      .err_count(err_b), .first_fail(first_fail_b), .fail_valid(fv_b)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_vec"},  32'(o_vec),  0);
      check({tag, "_busy"}, 32'(o_busy), 0);
      check({tag, "_done"}, 32'(o_done), 0);
      check({tag, "_pass"}, 32'(o_pass), 0);
      check({tag, "_err"},  32'(o_err),  0);
      check({tag, "_ff"},   32'(o_ff),   0);
      check({tag, "_fv"},   32'(o_fv),   0);
   endtask

   task automatic set_start(input bit h3, input logic v);
      if (h3) start_b = v; else start_a = v;
   endtask

   // One full sweep with per-cycle checks; poke = start pulse + expected change at vec 5,
   // hold = start kept high through DONE to check back-to-back restart timing.
   task automatic sweep(input bit h3, input logic [15:0] mask, input logic [15:0] table_v,
                        input bit poke, input bit hold);
      int h;
      int errs;
      int ff;
      bit fv;
      int n;
      h    = h3 ? 3 : 1;
      errs = 0;
      ff   = 0;
      fv   = 1'b0;
      for (int k = 0; k < 16; k++) begin
         if (table_v[k] != mask[k]) begin
            errs++;
            if (!fv) begin
               ff = k;
               fv = 1'b1;
            end
         end
      end
      sel      = h3;
      expected = mask;
      tt       = table_v;
      set_start(h3, 1'b1);
      tick();
      for (int c = 1; c <= 16*h + 1; c++) begin
         set_start(h3, hold || (poke && c == 5*h + 1));
         if (poke && c == 5*h + 1) expected = 16'($urandom);
         if (c <= 16*h) begin
            check("vec",  32'(o_vec),  32'((c - 1) / h));
            check("busy", 32'(o_busy), 1);
            check("done", 32'(o_done), 0);
         end else begin
            check("done_end",  32'(o_done), 1);
            check("busy_end",  32'(o_busy), 1);
            check("pass_end",  32'(o_pass), 32'(errs == 0));
            check("err_end",   32'(o_err),  32'(errs));
            check("ff_end",    32'(o_ff),   32'(ff));
            check("fv_end",    32'(o_fv),   32'(fv));
         end
         tick();
      end
      check("idle_busy", 32'(o_busy), 0);
      check("idle_done", 32'(o_done), 0);
      check("idle_vec",  32'(o_vec),  0);
      check("idle_err",  32'(o_err),  32'(errs));
      check("idle_pass", 32'(o_pass), 32'(errs == 0));
      if (hold) begin
         tick();
         set_start(h3, 1'b0);
         check("restart_busy", 32'(o_busy), 1);
         check("restart_vec",  32'(o_vec),  0);
         n = 0;
         while (!o_done && n < 200) begin
            tick();
            n++;
         end
         check("restart_done_seen", 32'(n < 200), 1);
         tick();
      end
      set_start(h3, 1'b0);
      tick();
   endtask

   initial begin
      rst      = 1'b1;
      start_a  = 1'b1;
      start_b  = 1'b1;
      expected = 16'hFFFF;
      tt       = 16'h0;
      sel      = 1'b0;
      for (int k = 0; k < 16; k++) begin
         logic [3:0] v;
         v = 4'(k);
         good_tt[k] = (v[3] & v[2]) | (v[1] & ~v[0]);
      end

      tick();
      tick();
      sel = 1'b0; check_all_zero("rst_a");
      sel = 1'b1; check_all_zero("rst_b");
      rst     = 1'b0;
      start_a = 1'b0;
      start_b = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         sel = 1'b0; check("post_rst_busy_a", 32'(o_busy), 0);
         sel = 1'b1; check("post_rst_busy_b", 32'(o_busy), 0);
      end

      sweep(1'b0, 16'hF444, good_tt, 1'b0, 1'b0);
      sweep(1'b0, 16'hF64C, good_tt, 1'b0, 1'b0);
      sweep(1'b1, 16'hF444, good_tt, 1'b0, 1'b0);
      sweep(1'b0, 16'hF64C, good_tt, 1'b1, 1'b0);
      sweep(1'b0, 16'hF444, good_tt, 1'b0, 1'b1);

      for (int r = 0; r < 8; r++) begin
         logic [15:0] m;
         m = (r % 3 == 0) ? 16'($urandom) : (good_tt ^ (16'($urandom) & 16'($urandom) & 16'($urandom)));
         sweep(1'($urandom_range(0, 1)), m, good_tt, 1'b0, 1'b0);
      end
      sweep(1'b1, 16'($urandom), 16'($urandom), 1'b0, 1'b0);
      sweep(1'b0, 16'hFFFF, 16'h0000, 1'b0, 1'b0);

      // Abort a sweep at vec 7 after one mismatch has already been counted
      sel      = 1'b0;
      expected = 16'hF64C;
      tt       = good_tt;
      start_a  = 1'b1;
      tick();
      start_a = 1'b0;
      for (int c = 1; c < 8; c++) tick();
      check("mid_vec7", 32'(o_vec), 7);
      check("mid_err1", 32'(o_err), 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_all_zero("mid_rst");
      for (int i = 0; i < 20; i++) begin
         check("mid_no_done", 32'(o_done), 0);
         check("mid_no_busy", 32'(o_busy), 0);
         tick();
      end
      sweep(1'b0, 16'hF444, good_tt, 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/truth_table_sweeper.md
# truth_table_sweeper

Sequencer that exhaustively exercises an N-input single-output combinational block (the 4-input `a,b,c,d -> f` style functions in our lab designs) in hardware rather than from a hand-written stimulus list. It steps all 2^N input vectors in ascending order, holds each for a programmable number of cycles, and samples the DUT output. It compares each sample against an expected truth-table mask and reports pass/fail, error count and first failing vector. It sits between a start/result interface and the DUT's input/output pins.

## Interface
- `N`, 4, number of DUT inputs; vectors 0..2^N-1
- `HOLD_CYCLES`, 1, cycles each vector is driven before sampling; legal range >=1
- Clocking: one clock; reset is synchronous and active-high. Ports are `clk` and `rst`.
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  begin a sweep; accepted only in IDLE
- `expected`  in  2^N  bit i = required DUT output for vector i; latched on accepted start
- `f`  in  1  DUT output
- `vec`  out  N  DUT input vector; MSB drives `a`, LSB drives `d` for N=4
- `busy`  out  1  high from the cycle after accepted start through the DONE cycle
- `done`  out  1  one-cycle pulse at sweep end
- `pass`  out  1  1 iff err_count==0; valid from done, held until next accepted start
- `err_count`  out  N+1  number of mismatching vectors
- `first_fail`  out  N  lowest failing vector index
- `fail_valid`  out  1  at least one mismatch recorded (first_fail meaningful)

## Operation
- FSM states: IDLE, DRIVE, DONE.
- IDLE:
  - vec=0, busy=0.
  - On start=1: latch `expected`, clear err_count, first_fail, fail_valid and pass, set hold_cnt=0, vec=0, then go to DRIVE.
- DRIVE:
  - vec is held while hold_cnt counts 0..HOLD_CYCLES-1.
  - In the cycle hold_cnt==HOLD_CYCLES-1, compare f against expected_q[vec].
  - On mismatch: err_count+=1. If fail_valid was 0, set first_fail=vec and fail_valid=1. Later failures never overwrite first_fail.
  - After that sample cycle: if vec==2^N-1, go to DONE; otherwise vec+=1 and hold_cnt=0.
- DONE:
  - done=1 and pass=(err_count==0) are registered together, so both are visible in the same cycle.
  - Next state is always IDLE. vec returns to 0 on entry to IDLE.
- Arithmetic:
  - err_count cannot overflow: max value 2^N fits in N+1 bits.
  - hold_cnt width is clog2(HOLD_CYCLES) with a minimum of 1 bit.
  - vec never wraps inside a sweep.
- start is ignored in DRIVE and DONE; it is not queued. A start held high continuously starts a new sweep from IDLE on the cycle after DONE.
- Changes to `expected` during a sweep have no effect.
- Results (pass, err_count, first_fail, fail_valid) persist in IDLE until the next accepted start.

## Timing
- All outputs are registered.
- Reset values:
  - state=IDLE, vec=0, busy=0, done=0, pass=0, err_count=0, first_fail=0, fail_valid=0, hold_cnt=0, expected_q=0.
- rst has priority over start in the same cycle.
- Reset mid-sweep: outputs hold their reset values from the next edge, and done never pulses for the aborted sweep.
- Cycle numbering: start sampled high at the edge ending cycle 0.
  - Cycle 1: DRIVE with vec=0.
  - Vector k is driven in cycles 1+k·H .. (k+1)·H and sampled at the edge ending cycle (k+1)·H, where H=HOLD_CYCLES.
  - done=1 in cycle 2^N·H+1. This is cycle 17 for N=4, H=1.
  - IDLE in cycle 2^N·H+2.
- The DUT is combinational; it must settle within H cycles minus setup. H=1 requires single-cycle settling.

## Test plan
- **Reset:** rst=1 for 2 cycles with start=1 -> all outputs 0 and no sweep begins. After rst drops with start=0, the block stays idle.
- **Correct DUT:** f=a&b | c&~d, expected=16'hF444, N=4, H=1.
  - vec steps 0..15 in cycles 1..16.
  - Cycle 17: done=1, pass=1, err_count=0, fail_valid=0.
- **Faulty mask:** expected=16'hF64C (bits 3 and 9 flipped), same DUT.
  - Cycle 17: done=1, pass=0, err_count=2, first_fail=3, fail_valid=1.
- **Hold cycles:** H=3, correct DUT.
  - Each vec is held exactly 3 cycles.
  - done in cycle 49 with pass=1.
  - busy is high cycles 1..49.
- **Start while busy:** start pulsed at vec=5, and `expected` changed mid-sweep.
  - No restart, sweep result unchanged, single done pulse.
  - With start held high, the second sweep's vec=0 appears 2 cycles after done.
- **Reset mid-sweep:** rst at vec=7.
  - Next cycle: vec=0, busy=0, err_count=0.
  - No done pulse; a subsequent start runs a full clean sweep.
